fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Parametrised successor to the single-register instruction latch.
- Buffers up to DEPTH instruction words fetched from instruction memory and presents them in order to the decode stage with a valid/ready handshake.
- Supports a flush on branch/jump, a sticky overflow flag and an optional same-cycle bypass.
- Sits between instruction memory read data and the control unit / decoder.

Parameters:
- DATA_W, 8, instruction word width in bits.
- DEPTH, 4, number of buffer entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived; not overridden).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- fetch  input  1  write enable: ins_in is valid this cycle and is to be queued.
- ins_in  input  DATA_W  instruction word from instruction memory.
- flush  input  1  discard all queued words (taken branch/jump).
- ins_ready  input  1  decoder accepts ins_out this cycle.
- ins_valid  output  1  ins_out holds a valid queued word.
- ins_out  output  DATA_W  oldest queued word (head).
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  CNT_W  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a fetch was dropped because the queue was full.

Behaviour:
- Reset (async, while rst high): write/read pointers = 0, count = 0, every storage entry = 0, overflow = 0. Outputs: ins_valid = 0, ins_out = 0, full = 0, empty = 1, count = 0.
- Storage: circular buffer of DEPTH x DATA_W; pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- pop = ins_valid && ins_ready && !flush.
- push = fetch && !flush && (!full || pop). Push and pop in the same cycle is allowed when full; count is unchanged.
- Per edge:
  - push writes ins_in at wr_ptr and increments wr_ptr.
  - pop increments rd_ptr.
  - count += push - pop.
- ins_valid = !empty. ins_out = mem[rd_ptr] (combinational read of the head).
- Latency: a word fetched at edge N is visible on ins_out/ins_valid after edge N (one cycle, no bypass).
- Empty with ins_ready high: no pop; count stays 0, never underflows.
- Full, fetch high, no pop: word dropped, storage unchanged, overflow set to 1 at that edge. overflow clears only on flush or rst.
- Flush (highest priority):
  - at the edge, pointers = 0, count = 0, overflow = 0.
  - same-cycle fetch is discarded; same-cycle ins_ready has no effect.
  - storage contents are not cleared; the next word is visible one cycle after flush.
- Reset asserted mid-operation: immediate return to reset state; in-flight words lost.

Optional Feature:
- Macro FETCH_QUEUE_BYPASS_EN.
- Defined:
  - when empty && fetch && !flush: ins_valid = 1 and ins_out = ins_in combinationally in the same cycle.
  - if ins_ready is also high, the word is consumed and not stored (count stays 0).
  - if ins_ready is low, the word is stored normally.
- Undefined: no combinational path from ins_in/fetch to ins_out/ins_valid; one-cycle latency always.

Decomposition:
- Shared package (cpu_pkg): INS_W = 8 and the instruction word typedef used by the PC, memory and decoder.
- Natural sub-module: fetch_queue_mem, a DEPTH x DATA_W register array with synchronous write and combinational read, reset to 0.
- Pointer, count, handshake and overflow logic stay in fetch_queue.

Test Plan:
- Defaults, macro undefined. Reset, then fetch 0xA1, 0xB2, 0xC3 on consecutive cycles with ins_ready = 0 -> count = 3, ins_out = 0xA1, ins_valid = 1, empty = 0.
- Fill 4 words (0x10..0x13), then fetch 0x99 with no pop -> full = 1, overflow = 1, count = 4. Drain 4 -> ins_out sequence 0x10, 0x11, 0x12, 0x13; 0x99 never appears.
- Full queue, fetch 0x55 with ins_ready = 1 -> pop 0x10 and push 0x55 in the same edge; count stays 4, overflow stays 0. 0x55 emerges last after wrap-around.
- Queue holding 3 words, flush with fetch = 1 (0x77) and ins_ready = 1 -> next cycle count = 0, empty = 1, overflow = 0. A following fetch 0x88 appears as head one cycle later.
- Assert rst asynchronously mid-burst (count = 2) -> outputs return to reset values before the next clk edge.
- FETCH_QUEUE_BYPASS_EN defined, empty queue, fetch 0x3C with ins_ready = 1 -> ins_valid = 1 and ins_out = 0x3C in the same cycle; count remains 0 after the edge.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction fetch path: word width, word type and default queue depth.
package fetch_queue_pkg;

  localparam int INS_W    = 8;
  localparam int FQ_DEPTH = 4;

  typedef logic [INS_W-1:0] ins_word_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// DEPTH x DATA_W register array: synchronous write, combinational read, async clear to zero.
module fetch_queue_mem
  import fetch_queue_pkg::*;
#(
  parameter  int DATA_W = INS_W,
  parameter  int DEPTH  = FQ_DEPTH,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [PTR_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [PTR_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_queue.sv
// In-order instruction fetch queue with valid/ready drain, flush and sticky overflow.
// Optional same-cycle bypass when empty: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DATA_W = INS_W,
  parameter int DEPTH  = FQ_DEPTH,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch,
  input  logic [DATA_W-1:0] ins_in,
  input  logic              flush,
  input  logic              ins_ready,
  output logic              ins_valid,
  output logic [DATA_W-1:0] ins_out,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;

  logic              w_empty;
  logic              w_full;
  logic              w_valid;
  logic [DATA_W-1:0] w_head;
  logic [DATA_W-1:0] w_out;
  logic              w_take;
  logic              w_pop;
  logic              w_push;
  logic              w_store;
  logic              w_advance;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
  logic w_bypass;
  assign w_bypass = w_empty && fetch && !flush;
  assign w_valid  = !w_empty || w_bypass;
  assign w_out    = w_bypass ? ins_in : w_head;
  assign w_take   = w_bypass && ins_ready;
`else
  assign w_valid  = !w_empty;
  assign w_out    = w_head;
  assign w_take   = 1'b0;
`endif

  assign w_pop  = w_valid && ins_ready && !flush;
  assign w_push = fetch && !flush && (!w_full || w_pop);

  // A bypassed word that is consumed immediately never touches storage or pointers.
  assign w_store   = w_push && !w_take;
  assign w_advance = w_pop && !w_take;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_store) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_advance) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_store && !w_advance) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_advance && !w_store) begin
        r_count <= r_count - CNT_W'(1);
      end
      if (fetch && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  fetch_queue_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_store),
    .i_waddr (r_wr_ptr),
    .i_wdata (ins_in),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_head)
  );

  assign ins_valid = w_valid;
  assign ins_out   = w_out;
  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = r_count;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue at default parameters (DATA_W=8, DEPTH=4).
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       fetch;
  ins_word_t  ins_in;
  logic       flush;
  logic       ins_ready;
  logic       ins_valid;
  ins_word_t  ins_out;
  logic       full;
  logic       empty;
  logic [2:0] count;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_queue #(
    .DATA_W (8),
    .DEPTH  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fetch     (fetch),
    .ins_in    (ins_in),
    .flush     (flush),
    .ins_ready (ins_ready),
    .ins_valid (ins_valid),
    .ins_out   (ins_out),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; fetch = 1'b0; ins_in = '0; flush = 1'b0; ins_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_valid", 32'(ins_valid), 32'h0);
    check("rst_out",   32'(ins_out),   32'h0);
    check("rst_full",  32'(full),      32'h0);
    check("rst_empty", 32'(empty),     32'h1);
    check("rst_count", 32'(count),     32'h0);
    check("rst_ovf",   32'(overflow),  32'h0);

    // Three fetches, no drain
    fetch = 1'b1; ins_in = 8'hA1;
    #1;
`ifndef FETCH_QUEUE_BYPASS_EN
    check("no_comb_path_valid", 32'(ins_valid), 32'h0);
`endif
    step();
    check("lat1_valid", 32'(ins_valid), 32'h1);
    check("lat1_out",   32'(ins_out),   32'hA1);
    ins_in = 8'hB2; step();
    ins_in = 8'hC3; step();
    fetch = 1'b0;
    #1;
    check("fill3_count", 32'(count),     32'h3);
    check("fill3_out",   32'(ins_out),   32'hA1);
    check("fill3_valid", 32'(ins_valid), 32'h1);
    check("fill3_empty", 32'(empty),     32'h0);

    // Flush with same-cycle fetch and ready
    flush = 1'b1; fetch = 1'b1; ins_in = 8'h77; ins_ready = 1'b1;
    step();
    flush = 1'b0; fetch = 1'b0; ins_ready = 1'b0;
    #1;
    check("flush_count", 32'(count),     32'h0);
    check("flush_empty", 32'(empty),     32'h1);
    check("flush_ovf",   32'(overflow),  32'h0);
    check("flush_valid", 32'(ins_valid), 32'h0);
    fetch = 1'b1; ins_in = 8'h88;
    step();
    fetch = 1'b0;
    #1;
    check("post_flush_out",   32'(ins_out), 32'h88);
    check("post_flush_count", 32'(count),   32'h1);
    flush = 1'b1; step(); flush = 1'b0;

    // Fill to full, then an overflowing fetch
    fetch = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ins_in = 8'(8'h10 + k);
      step();
    end
    ins_in = 8'h99; step();
    fetch = 1'b0;
    #1;
    check("ovf_full",  32'(full),     32'h1);
    check("ovf_flag",  32'(overflow), 32'h1);
    check("ovf_count", 32'(count),    32'h4);
    ins_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("drain_out", 32'(ins_out), 32'(8'h10 + k));
      step();
    end
    #1;
    check("drained_empty", 32'(empty),     32'h1);
    check("drained_valid", 32'(ins_valid), 32'h0);
    check("sticky_ovf",    32'(overflow),  32'h1);
    step();
    check("no_underflow",  32'(count),     32'h0);
    ins_ready = 1'b0;
    flush = 1'b1; step(); flush = 1'b0;
    #1;
    check("ovf_cleared", 32'(overflow), 32'h0);

    // Full queue, simultaneous push and pop, wrap-around
    fetch = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ins_in = 8'(8'h10 + k);
      step();
    end
    ins_in = 8'h55; ins_ready = 1'b1;
    step();
    fetch = 1'b0;
    #1;
    check("pp_count", 32'(count),    32'h4);
    check("pp_ovf",   32'(overflow), 32'h0);
    check("pp_full",  32'(full),     32'h1);
    check("pp_head",  32'(ins_out),  32'h11);
    step(); step(); step();
    #1;
    check("wrap_last_out",   32'(ins_out), 32'h55);
    check("wrap_last_count", 32'(count),   32'h1);
    step();
    ins_ready = 1'b0;
    check("wrap_drained", 32'(count), 32'h0);

    // Asynchronous reset mid-burst
    fetch = 1'b1; ins_in = 8'hE1; step();
    ins_in = 8'hE2; step();
    fetch = 1'b0;
    check("burst_count", 32'(count), 32'h2);
    rst = 1'b1;
    #1;
    check("arst_count", 32'(count),     32'h0);
    check("arst_valid", 32'(ins_valid), 32'h0);
    check("arst_out",   32'(ins_out),   32'h0);
    check("arst_empty", 32'(empty),     32'h1);
    step();
    rst = 1'b0;
    #1;

    // Same-cycle behaviour on an empty queue
    fetch = 1'b1; ins_in = 8'h3C; ins_ready = 1'b1;
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    check("byp_valid", 32'(ins_valid), 32'h1);
    check("byp_out",   32'(ins_out),   32'h3C);
    step();
    fetch = 1'b0; ins_ready = 1'b0;
    #1;
    check("byp_count", 32'(count), 32'h0);
    check("byp_empty", 32'(empty), 32'h1);
`else
    check("nobyp_valid", 32'(ins_valid), 32'h0);
    check("nobyp_out",   32'(ins_out),   32'h0);
    step();
    fetch = 1'b0; ins_ready = 1'b0;
    #1;
    check("nobyp_count", 32'(count),   32'h1);
    check("nobyp_head",  32'(ins_out), 32'h3C);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
